// File: rtl/adc_decimate_fifo_if.sv
// Sample-in / word-out bus of the ADC decimator: capture side driven by the ADC front end,
// read side and status flags consumed by the downstream reader.
interface adc_decimate_fifo_if #(
    parameter int DATAWIDTH = 14
);
    logic                 adc_en;
    logic [DATAWIDTH-1:0] adc_data_in;
    logic                 rd_en;
    logic [DATAWIDTH-1:0] rd_data;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_almst_empty;
    logic                 fifo_above_half;
    logic                 overflow;

    modport master (
        output adc_en, adc_data_in, rd_en,
        input  rd_data, fifo_full, fifo_empty, fifo_almst_empty, fifo_above_half, overflow
    );

    modport slave (
        input  adc_en, adc_data_in, rd_en,
        output rd_data, fifo_full, fifo_empty, fifo_almst_empty, fifo_above_half, overflow
    );
endinterface

// File: rtl/adc_decimate_fifo.sv
// Block-average decimator: 2^SAMPLE_RATE ADC samples are summed and truncated to one word,
// which is queued in an output FIFO with occupancy flags and a sticky overflow flag.
module adc_decimate_fifo #(
    parameter int DATAWIDTH   = 14,
    parameter int FIFO_DEPTH  = 64,
    parameter int SAMPLE_RATE = 4
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    adc_decimate_fifo_if.slave      bus
);
    localparam int ACC_W = DATAWIDTH + SAMPLE_RATE;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam logic [SAMPLE_RATE-1:0] CNT_LAST  = '1;
    localparam logic [AW:0]            FULL_CNT  = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]            HALF_CNT  = (AW+1)'(FIFO_DEPTH / 2);
    localparam logic [AW:0]            ONE_CNT   = (AW+1)'(1);

    // Block sum divided by the block length; dropping the low bits truncates toward zero.
    function automatic logic [DATAWIDTH-1:0] trunc_avg(input logic [ACC_W-1:0] sum);
        return sum[ACC_W-1:SAMPLE_RATE];
    endfunction

    logic                   vld_p0;
    logic [DATAWIDTH-1:0]   sample_p0;
    logic                   vld_p1;
    logic [ACC_W-1:0]       acc_p1;
    logic [SAMPLE_RATE-1:0] cnt_p1;
    logic [DATAWIDTH-1:0]   result_p1;
    logic [ACC_W-1:0]       sum_p1;

    logic [DATAWIDTH-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [AW:0]            count;
    logic                   wr_acc;
    logic                   rd_acc;

    // ---- stage p0: input capture ----
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            vld_p0    <= 1'b0;
            sample_p0 <= '0;
        end else begin
            vld_p0    <= bus.adc_en;
            sample_p0 <= bus.adc_data_in;
        end
    end

    // ---- stage p1: block accumulation ----
    assign sum_p1 = acc_p1 + ACC_W'(sample_p0);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            acc_p1    <= '0;
            cnt_p1    <= '0;
            result_p1 <= '0;
            vld_p1    <= 1'b0;
        end else if (!vld_p0) begin
            // A gap in the enable abandons the partial block.
            acc_p1 <= '0;
            cnt_p1 <= '0;
            vld_p1 <= 1'b0;
        end else if (cnt_p1 == CNT_LAST) begin
            result_p1 <= trunc_avg(sum_p1);
            vld_p1    <= 1'b1;
            acc_p1    <= '0;
            cnt_p1    <= '0;
        end else begin
            acc_p1 <= sum_p1;
            cnt_p1 <= cnt_p1 + 1'b1;
            vld_p1 <= 1'b0;
        end
    end

    // ---- stage p2: output FIFO ----
    assign bus.fifo_empty       = (count == '0);
    assign bus.fifo_almst_empty = (count <= ONE_CNT);
    assign bus.fifo_full        = (count == FULL_CNT);
    assign bus.fifo_above_half  = (count >= HALF_CNT);

    // A read on the same edge frees a slot, so a push into a full FIFO is still accepted.
    assign rd_acc = bus.rd_en && !bus.fifo_empty;
    assign wr_acc = vld_p1 && (!bus.fifo_full || rd_acc);

    always_ff @(posedge clk_in) begin
        if (wr_acc) begin
            mem[wr_ptr] <= result_p1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            bus.rd_data  <= '0;
            bus.overflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr      <= rd_ptr + 1'b1;
                bus.rd_data <= mem[rd_ptr];
            end
            if (wr_acc && !rd_acc) begin
                count <= count + ONE_CNT;
            end else if (rd_acc && !wr_acc) begin
                count <= count - ONE_CNT;
            end
            if (vld_p1 && !wr_acc) begin
                bus.overflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_adc_decimate_fifo.sv
// Directed bench for adc_decimate_fifo: a vector table of single-block averages followed by
// hand-written sequences for gating, overflow, mid-block reset and simultaneous access.
module tb_adc_decimate_fifo;
    localparam int DW = 14;

    typedef struct {
        string      name;
        logic [13:0] base;
        bit          ramp;
        logic [13:0] exp_word;
    } vec_t;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    int   checks = 0;
    int   errors = 0;

    adc_decimate_fifo_if #(.DATAWIDTH(DW)) dif ();

    adc_decimate_fifo #(
        .DATAWIDTH(DW),
        .FIFO_DEPTH(64),
        .SAMPLE_RATE(4)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .bus(dif.slave)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [13:0] v, input logic en);
        dif.adc_data_in = v;
        dif.adc_en      = en;
        tick();
    endtask

    task automatic do_block(input logic [13:0] base, input bit ramp);
        for (int i = 0; i < 16; i++) begin
            send(ramp ? base + 14'(i) : base, 1'b1);
        end
        dif.adc_en = 1'b0;
    endtask

    // Block then two idle edges, after which the word has landed in the FIFO.
    task automatic block_flush(input logic [13:0] base);
        do_block(base, 1'b0);
        tick();
        tick();
    endtask

    task automatic read_word();
        int n = 0;
        while (dif.fifo_empty && n < 8) begin
            tick();
            n++;
        end
        if (dif.fifo_empty) begin
            check("read_wait_timeout", 32'(dif.fifo_empty), 32'd0);
        end
        dif.rd_en = 1'b1;
        tick();
        dif.rd_en = 1'b0;
    endtask

    function automatic logic [13:0] ovf_val(input int b);
        return 14'(b * 100 + 3);
    endfunction

    function automatic logic [13:0] full_val(input int b);
        return 14'(b * 50 + 1);
    endfunction

    vec_t vecs[6];

    initial begin
        vecs[0] = '{"const_1000",  14'h1000, 1'b0, 14'h1000};
        vecs[1] = '{"ramp_0_15",   14'h0000, 1'b1, 14'h0007};
        vecs[2] = '{"full_scale",  14'h3FFF, 1'b0, 14'h3FFF};
        vecs[3] = '{"zero",        14'h0000, 1'b0, 14'h0000};
        vecs[4] = '{"ramp_top",    14'h3FF0, 1'b1, 14'h3FF7};
        vecs[5] = '{"ramp_5_trnc", 14'h0005, 1'b1, 14'h000C};

        dif.adc_en      = 1'b0;
        dif.adc_data_in = '0;
        dif.rd_en       = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_rd_data",    32'(dif.rd_data),          32'd0);
        check("rst_empty",      32'(dif.fifo_empty),       32'd1);
        check("rst_almst",      32'(dif.fifo_almst_empty), 32'd1);
        check("rst_full",       32'(dif.fifo_full),        32'd0);
        check("rst_above_half", 32'(dif.fifo_above_half),  32'd0);
        check("rst_overflow",   32'(dif.overflow),         32'd0);
        rst_in = 1'b1;
        tick();

        // Single-block vectors, including edge-exact latency of the first word
        foreach (vecs[i]) begin
            do_block(vecs[i].base, vecs[i].ramp);
            tick();
            check({vecs[i].name, "_empty_k2"}, 32'(dif.fifo_empty), 32'd1);
            tick();
            check({vecs[i].name, "_empty_k3"}, 32'(dif.fifo_empty), 32'd0);
            check({vecs[i].name, "_almst"},    32'(dif.fifo_almst_empty), 32'd1);
            read_word();
            check({vecs[i].name, "_word"},     32'(dif.rd_data), 32'(vecs[i].exp_word));
            check({vecs[i].name, "_drained"},  32'(dif.fifo_empty), 32'd1);
        end

        // Enable gap discards the 10-sample partial block
        for (int i = 0; i < 10; i++) send(14'd500, 1'b1);
        send(14'd500, 1'b0);
        block_flush(14'd100);
        check("gate_one_word", 32'(dif.fifo_almst_empty), 32'd1);
        read_word();
        check("gate_word", 32'(dif.rd_data), 32'd100);
        check("gate_empty", 32'(dif.fifo_empty), 32'd1);

        // Push into empty FIFO with rd_en on the same edge: read ignored
        do_block(14'h02AB, 1'b0);
        tick();
        dif.rd_en = 1'b1;
        tick();
        dif.rd_en = 1'b0;
        check("simul_empty_rd_hold", 32'(dif.rd_data), 32'd100);
        check("simul_empty_count1", 32'(dif.fifo_empty), 32'd0);
        check("simul_empty_almst",  32'(dif.fifo_almst_empty), 32'd1);
        read_word();
        check("simul_empty_word", 32'(dif.rd_data), 32'h02AB);

        // 65 blocks with no reads: thresholds, drop and sticky overflow
        for (int b = 0; b < 65; b++) begin
            block_flush(ovf_val(b));
            if (b == 0)  check("ovf_almst_1",  32'(dif.fifo_almst_empty), 32'd1);
            if (b == 1)  check("ovf_almst_2",  32'(dif.fifo_almst_empty), 32'd0);
            if (b == 30) check("ovf_half_31",  32'(dif.fifo_above_half),  32'd0);
            if (b == 31) check("ovf_half_32",  32'(dif.fifo_above_half),  32'd1);
            if (b == 62) check("ovf_full_63",  32'(dif.fifo_full),        32'd0);
            if (b == 63) begin
                check("ovf_full_64",  32'(dif.fifo_full), 32'd1);
                check("ovf_flag_64",  32'(dif.overflow),  32'd0);
            end
            if (b == 64) begin
                check("ovf_flag_65",  32'(dif.overflow),  32'd1);
                check("ovf_full_65",  32'(dif.fifo_full), 32'd1);
            end
        end
        for (int b = 0; b < 64; b++) begin
            read_word();
            check($sformatf("ovf_read_%0d", b), 32'(dif.rd_data), 32'(ovf_val(b)));
        end
        check("ovf_final_empty", 32'(dif.fifo_empty), 32'd1);
        check("ovf_sticky",      32'(dif.overflow),   32'd1);

        // Reset in the middle of a block
        for (int i = 0; i < 8; i++) send(14'h3FFF, 1'b1);
        #1;
        rst_in = 1'b0;
        #1;
        check("mid_rst_rd_data",  32'(dif.rd_data),          32'd0);
        check("mid_rst_empty",    32'(dif.fifo_empty),       32'd1);
        check("mid_rst_almst",    32'(dif.fifo_almst_empty), 32'd1);
        check("mid_rst_full",     32'(dif.fifo_full),        32'd0);
        check("mid_rst_half",     32'(dif.fifo_above_half),  32'd0);
        check("mid_rst_overflow", 32'(dif.overflow),         32'd0);
        dif.adc_en = 1'b0;
        tick();
        rst_in = 1'b1;
        block_flush(14'd100);
        check("mid_rst_one_word", 32'(dif.fifo_almst_empty), 32'd1);
        check("mid_rst_nonempty", 32'(dif.fifo_empty), 32'd0);
        read_word();
        check("mid_rst_word", 32'(dif.rd_data), 32'd100);
        check("mid_rst_ovf",  32'(dif.overflow), 32'd0);

        // Push into full FIFO with rd_en on the same edge
        for (int b = 0; b < 64; b++) block_flush(full_val(b));
        check("sfull_full",  32'(dif.fifo_full), 32'd1);
        do_block(full_val(64), 1'b0);
        tick();
        dif.rd_en = 1'b1;
        tick();
        dif.rd_en = 1'b0;
        check("sfull_head",   32'(dif.rd_data),   32'(full_val(0)));
        check("sfull_still",  32'(dif.fifo_full), 32'd1);
        check("sfull_no_ovf", 32'(dif.overflow),  32'd0);
        for (int b = 1; b <= 64; b++) begin
            read_word();
            check($sformatf("sfull_read_%0d", b), 32'(dif.rd_data), 32'(full_val(b)));
        end
        check("sfull_empty", 32'(dif.fifo_empty), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end
endmodule
